// File: rtl/sweep_pkg.sv
// Shared types for the exhaustive vector sweep sequencer.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } sweep_state_e;

  localparam int SETTLE_W = 8;

endpackage

// File: rtl/vector_sweep_ctrl.sv
// Sweeps dut_in through 0..2^N_IN-1 and streams one {vector, response} record per vector.
// SETTLE+2 cycles per record; a low rec_ready stalls the sweep in EMIT with dut_in held.
module vector_sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 0
) (
  input  logic              CK,
  input  logic              reset,
  input  logic              start,
  output logic [N_IN-1:0]   dut_in,
  input  logic [N_OUT-1:0]  dut_out,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [N_IN-1:0]   rec_vec,
  output logic [N_OUT-1:0]  rec_resp,
  output logic              busy,
  output logic              done,
  output logic [N_IN:0]     hit_count
);

  localparam int HIT_W = N_IN + 1;
  localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE);

  sweep_state_e           state, state_nxt;
  logic [SETTLE_W-1:0]    scnt, scnt_nxt;
  logic [N_IN-1:0]        dut_in_nxt;
  logic                   rec_valid_nxt;
  logic [N_IN-1:0]        rec_vec_nxt;
  logic [N_OUT-1:0]       rec_resp_nxt;
  logic [N_IN:0]          hit_count_nxt;

  always_ff @(posedge CK) begin
    if (reset) begin
      state     <= IDLE;
      scnt      <= '0;
      dut_in    <= '0;
      rec_valid <= 1'b0;
      rec_vec   <= '0;
      rec_resp  <= '0;
      hit_count <= '0;
    end else begin
      state     <= state_nxt;
      scnt      <= scnt_nxt;
      dut_in    <= dut_in_nxt;
      rec_valid <= rec_valid_nxt;
      rec_vec   <= rec_vec_nxt;
      rec_resp  <= rec_resp_nxt;
      hit_count <= hit_count_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    scnt_nxt      = scnt;
    dut_in_nxt    = dut_in;
    rec_valid_nxt = rec_valid;
    rec_vec_nxt   = rec_vec;
    rec_resp_nxt  = rec_resp;
    hit_count_nxt = hit_count;
    busy          = (state != IDLE);
    done          = (state == DONE);

    case (state)
      IDLE: begin
        if (start) begin
          dut_in_nxt    = '0;
          scnt_nxt      = SETTLE_INIT;
          hit_count_nxt = '0;
          state_nxt     = WAIT;
        end
      end
      WAIT: begin
        if (scnt != '0) begin
          scnt_nxt = scnt - SETTLE_W'(1);
        end else begin
          rec_vec_nxt   = dut_in;
          rec_resp_nxt  = dut_out;
          rec_valid_nxt = 1'b1;
          hit_count_nxt = hit_count + HIT_W'(|dut_out);
          state_nxt     = EMIT;
        end
      end
      EMIT: begin
        if (rec_valid && rec_ready) begin
          rec_valid_nxt = 1'b0;
          // The all-ones vector ends the sweep, so dut_in never wraps.
          if (&dut_in) begin
            state_nxt = DONE;
          end else begin
            dut_in_nxt = dut_in + N_IN'(1);
            scnt_nxt   = SETTLE_INIT;
            state_nxt  = WAIT;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_vector_sweep_ctrl.sv
// Directed bench for vector_sweep_ctrl: three instances cover AND/SETTLE=0, XOR/SETTLE=2 and a 1-bit sweep.
module tb_vector_sweep_ctrl;

  logic ck;
  logic reset;

  logic       start_a, rec_ready_a, rec_valid_a, busy_a, done_a;
  logic [2:0] dut_in_a, rec_vec_a;
  logic [0:0] dut_out_a, rec_resp_a;
  logic [3:0] hit_a;

  logic       start_b, rec_ready_b, rec_valid_b, busy_b, done_b;
  logic [2:0] dut_in_b, rec_vec_b;
  logic [0:0] dut_out_b, rec_resp_b;
  logic [3:0] hit_b;

  logic       start_c, rec_ready_c, rec_valid_c, busy_c, done_c;
  logic [0:0] dut_in_c, rec_vec_c;
  logic [1:0] dut_out_c, rec_resp_c;
  logic [1:0] hit_c;

  int checks = 0;
  int errors = 0;

  assign dut_out_a = &dut_in_a;
  assign dut_out_b = ^dut_in_b;
  assign dut_out_c = {dut_in_c, ~dut_in_c};

  vector_sweep_ctrl #(.N_IN(3), .N_OUT(1), .SETTLE(0)) u_dut_a (
    .CK(ck), .reset(reset), .start(start_a), .dut_in(dut_in_a), .dut_out(dut_out_a),
    .rec_valid(rec_valid_a), .rec_ready(rec_ready_a), .rec_vec(rec_vec_a), .rec_resp(rec_resp_a),
    .busy(busy_a), .done(done_a), .hit_count(hit_a)
  );

  vector_sweep_ctrl #(.N_IN(3), .N_OUT(1), .SETTLE(2)) u_dut_b (
    .CK(ck), .reset(reset), .start(start_b), .dut_in(dut_in_b), .dut_out(dut_out_b),
    .rec_valid(rec_valid_b), .rec_ready(rec_ready_b), .rec_vec(rec_vec_b), .rec_resp(rec_resp_b),
    .busy(busy_b), .done(done_b), .hit_count(hit_b)
  );

  vector_sweep_ctrl #(.N_IN(1), .N_OUT(2), .SETTLE(0)) u_dut_c (
    .CK(ck), .reset(reset), .start(start_c), .dut_in(dut_in_c), .dut_out(dut_out_c),
    .rec_valid(rec_valid_c), .rec_ready(rec_ready_c), .rec_vec(rec_vec_c), .rec_resp(rec_resp_c),
    .busy(busy_c), .done(done_c), .hit_count(hit_c)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sweep on instance a (3-input AND). Cycle c is counted from the period that holds start.
  task automatic run_a(input int stall_idx, input int stall_len, input bit poke);
    int c = 1;
    int nrec = 0;
    int held = 0;
    int done_cyc = -1;
    start_a = 1'b1;
    rec_ready_a = 1'b1;
    @(negedge ck);
    start_a = 1'b0;
    while (c < 200 && done_cyc < 0) begin
      if (c == 1) begin
        chk("a_hit_cleared", hit_a, 0);
        chk("a_first_vec", dut_in_a, 0);
      end
      start_a = poke && (c == 5);
      if (done_a) begin
        done_cyc = c;
        start_a = poke;
      end else begin
        chk("a_busy", busy_a, 1);
        if (rec_valid_a) begin
          if (nrec == stall_idx && held < stall_len) begin
            rec_ready_a = 1'b0;
            chk("a_stall_vec", rec_vec_a, 3);
            chk("a_stall_resp", rec_resp_a, 0);
            chk("a_stall_dut_in", dut_in_a, 3);
            held++;
          end else begin
            rec_ready_a = 1'b1;
            chk("a_rec_vec", rec_vec_a, nrec);
            chk("a_rec_resp", rec_resp_a, (nrec == 7) ? 1 : 0);
            if (stall_idx < 0) chk("a_rec_cycle", c, 2 + 2 * nrec);
            nrec++;
          end
        end else begin
          rec_ready_a = 1'b1;
        end
      end
      @(negedge ck);
      c++;
    end
    start_a = 1'b0;
    chk("a_done_cycle", done_cyc, (stall_idx >= 0) ? 17 + stall_len : 17);
    chk("a_nrec", nrec, 8);
    chk("a_hit_count", hit_a, 1);
    chk("a_idle_after_done", busy_a, 0);
    chk("a_done_single", done_a, 0);
    @(negedge ck);
    chk("a_still_idle", busy_a, 0);
  endtask

  initial begin
    int c;
    int nrec;
    int done_cyc;
    reset = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    rec_ready_a = 1'b1; rec_ready_b = 1'b1; rec_ready_c = 1'b1;
    repeat (3) @(negedge ck);

    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_valid_a", rec_valid_a, 0);
    chk("rst_dut_in_a", dut_in_a, 0);
    chk("rst_hit_a", hit_a, 0);
    chk("rst_vec_a", rec_vec_a, 0);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_valid_b", rec_valid_b, 0);
    chk("rst_busy_c", busy_c, 0);
    chk("rst_hit_c", hit_c, 0);
    reset = 1'b0;
    @(negedge ck);

    // T1: plain AND sweep; T3: stall record 3 for 5 cycles.
    run_a(-1, 0, 1'b0);
    run_a(3, 5, 1'b0);
    // T5: start pulsed mid-sweep and in the DONE cycle, then a fresh sweep.
    run_a(-1, 0, 1'b1);
    chk("t5_hit_kept", hit_a, 1);
    run_a(-1, 0, 1'b0);

    // T2: XOR cone, SETTLE=2 -> records every 4 cycles starting at cycle 4.
    nrec = 0; done_cyc = -1; c = 1;
    start_b = 1'b1;
    @(negedge ck);
    start_b = 1'b0;
    while (c < 200 && done_cyc < 0) begin
      if (done_b) begin
        done_cyc = c;
      end else if (rec_valid_b) begin
        chk("b_rec_vec", rec_vec_b, nrec);
        chk("b_rec_resp", rec_resp_b, (nrec == 1 || nrec == 2 || nrec == 4 || nrec == 7) ? 1 : 0);
        chk("b_rec_cycle", c, 4 + 4 * nrec);
        nrec++;
      end
      @(negedge ck);
      c++;
    end
    chk("b_done_cycle", done_cyc, 33);
    chk("b_nrec", nrec, 8);
    chk("b_hit_count", hit_b, 4);
    chk("b_idle", busy_b, 0);

    // T4: reset while instance b presents vector 101.
    c = 0;
    start_b = 1'b1;
    @(negedge ck);
    start_b = 1'b0;
    while (c < 100 && !(rec_valid_b && rec_vec_b == 3'd5)) begin
      @(negedge ck);
      c++;
    end
    chk("t4_reached_101", rec_vec_b, 5);
    chk("t4_hit_before", hit_b, 3);
    rec_ready_b = 1'b0;
    reset = 1'b1;
    @(negedge ck);
    reset = 1'b0;
    chk("t4_busy", busy_b, 0);
    chk("t4_valid", rec_valid_b, 0);
    chk("t4_dut_in", dut_in_b, 0);
    chk("t4_hit", hit_b, 0);
    chk("t4_done", done_b, 0);
    rec_ready_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ck);
      chk("t4_no_done", done_b, 0);
      chk("t4_stays_idle", busy_b, 0);
    end

    // T6: 1-bit sweep with 2-bit response {x, ~x}.
    nrec = 0; done_cyc = -1; c = 1;
    start_c = 1'b1;
    @(negedge ck);
    start_c = 1'b0;
    while (c < 100 && done_cyc < 0) begin
      if (done_c) begin
        done_cyc = c;
      end else if (rec_valid_c) begin
        chk("c_rec_vec", rec_vec_c, nrec);
        chk("c_rec_resp", rec_resp_c, (nrec == 0) ? 1 : 2);
        chk("c_rec_cycle", c, 2 + 2 * nrec);
        nrec++;
      end
      @(negedge ck);
      c++;
    end
    chk("c_done_cycle", done_cyc, 5);
    chk("c_nrec", nrec, 2);
    chk("c_hit_count", hit_c, 2);
    chk("c_idle", busy_c, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
